// File: rtl/rom_burst_reader.sv
// rom_burst_reader: bus initiator that reads a run of consecutive words and streams them out
module rom_burst_reader #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 11,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              cs_,
    output logic              as_,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rdy_
);
    typedef enum logic [2:0] {IDLE, REQ, ACCESS, WAIT, DONE} state_t;
    localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d, out_valid_q, out_valid_d;
    logic bus_req_q, bus_req_d, cs_q, cs_d, as_q, as_d, zdone;
    // next-state, datapath and registered-output values
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        zdone       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                err_d = 1'b0;
                if (count != '0) begin
                    addr_d  = start_addr;
                    cnt_d   = count;
                    state_d = REQ;
                end else begin
                    zdone = 1'b1;
                end
            end
            REQ: state_d = bus_grnt_ ? REQ : ACCESS;
            ACCESS: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: if (!rdy_) begin
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
                addr_d      = addr_q + ADDR_W'(1);
                cnt_d       = cnt_q - CNT_W'(1);
                state_d     = (cnt_q == CNT_W'(1)) ? DONE : ACCESS;
            end else if (tcnt_q == TLIM) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                tcnt_d = tcnt_q + 16'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        bus_req_d = !(state_d == REQ || state_d == ACCESS || state_d == WAIT);
        cs_d      = state_d != ACCESS;
        as_d      = state_d != ACCESS;
        busy_d    = state_d != IDLE;
        done_d    = (state_d == DONE) || zdone;
    end
    // state and all outputs registered, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b1;
            cs_q        <= 1'b1;
            as_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bus_req_q   <= bus_req_d;
            cs_q        <= cs_d;
            as_q        <= as_d;
        end
    end
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign bus_req_  = bus_req_q;
    assign cs_       = cs_q;
    assign as_       = as_q;
    assign rw        = 1'b1;
    assign addr      = addr_q;
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed table-driven bench with a registered-rdy_ ROM slave model
module tb_rom_burst_reader;
    logic clk, reset, start, busy, done, err, out_valid, bus_req_, bus_grnt_, cs_, as_, rw, rdy_;
    logic [29:0] start_addr, addr, dead_addr, ad;
    logic [10:0] count;
    logic [31:0] out_data, rd_data;
    logic dead_en, pend;
    int slv_dly, wl;
    int checks = 0, errors = 0;

    typedef struct {
        logic [29:0] a;
        logic [10:0] n;
        int g;
        int d;
        logic dead;
        logic [29:0] da;
        logic poke;
        int exp_words;
        logic exp_err;
        int exp_done;
    } vec_t;
    vec_t tbl[8];

    rom_burst_reader #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .count(count),
        .busy(busy), .done(done), .err(err), .out_valid(out_valid), .out_data(out_data),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .cs_(cs_), .as_(as_), .rw(rw),
        .addr(addr), .rd_data(rd_data), .rdy_(rdy_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h5A5A_0000;
    endfunction

    // slave: rdy_ registered on a strobe, optionally delayed or never given
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_ <= 1'b1; pend <= 1'b0; wl <= 0; rd_data <= '0; ad <= '0;
        end else begin
            rdy_ <= 1'b1;
            if (!cs_ && !as_) begin
                if (!(dead_en && addr == dead_addr)) begin
                    if (slv_dly == 0) begin
                        rdy_ <= 1'b0; rd_data <= rom(addr);
                    end else begin
                        pend <= 1'b1; wl <= slv_dly - 1; ad <= addr;
                    end
                end
            end else if (pend) begin
                if (wl == 0) begin
                    rdy_ <= 1'b0; rd_data <= rom(ad); pend <= 1'b0;
                end else wl <= wl - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int cyc, nw, ns, first, early;
        logic fin;
        logic [29:0] ea;
        slv_dly = v.d; dead_en = v.dead; dead_addr = v.da;
        @(negedge clk);
        start = 1'b1; start_addr = v.a; count = v.n; bus_grnt_ = (v.g == 0) ? 1'b0 : 1'b1;
        cyc = 0; fin = 1'b0; nw = 0; ns = 0; first = -1; early = 0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (v.poke && cyc == 2) begin
                start = 1'b1; start_addr = 30'h200; count = 11'd5;
            end
            if (cyc == 1) begin
                chk("busy_after_start", busy, 1);
                chk("err_cleared_by_start", err, 0);
            end
            if (!as_) begin
                ea = v.a + 30'(ns);
                chk("strobe_addr", addr, ea);
                chk("strobe_cs", cs_, 0);
                ns++;
                if (bus_grnt_) early++;
            end
            if (out_valid) begin
                ea = v.a + 30'(nw);
                chk("out_data", out_data, rom(ea));
                if (first < 0) first = cyc;
                nw++;
            end
            if (done) begin
                fin = 1'b1;
                chk("done_cycle", cyc, v.exp_done);
                chk("err_at_done", err, v.exp_err);
                chk("bus_req_in_done", bus_req_, 1);
                chk("busy_in_done", busy, 1);
            end
            if (cyc > v.g) bus_grnt_ = 1'b0;
        end
        if (!fin) chk("done_timeout", 0, 1);
        chk("word_count", nw, v.exp_words);
        chk("strobe_count", ns, v.exp_words + int'(v.exp_err));
        chk("strobe_before_grant", early, 0);
        if (v.exp_words > 0) chk("first_latency", first - 1, v.g + 3 + v.d);
        @(negedge clk);
        bus_grnt_ = 1'b1;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("bus_req_idle", bus_req_, 1);
    endtask

    initial begin
        tbl[0] = '{30'h10, 11'd4, 0, 0, 1'b0, 30'h0, 1'b0, 4, 1'b0, 10};
        tbl[1] = '{30'h10, 11'd4, 7, 0, 1'b0, 30'h0, 1'b0, 4, 1'b0, 17};
        tbl[2] = '{30'h3FFFFFFE, 11'd3, 0, 0, 1'b0, 30'h0, 1'b0, 3, 1'b0, 8};
        tbl[3] = '{30'h20, 11'd3, 0, 0, 1'b1, 30'h21, 1'b0, 1, 1'b1, 13};
        tbl[4] = '{30'h40, 11'd1, 0, 7, 1'b0, 30'h0, 1'b0, 1, 1'b0, 11};
        tbl[5] = '{30'h50, 11'd1, 0, 8, 1'b0, 30'h0, 1'b0, 0, 1'b1, 11};
        tbl[6] = '{30'h60, 11'd2, 3, 1, 1'b0, 30'h0, 1'b0, 2, 1'b0, 11};
        tbl[7] = '{30'h100, 11'd2, 2, 0, 1'b0, 30'h0, 1'b1, 2, 1'b0, 8};
        reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; bus_grnt_ = 1'b1;
        dead_en = 1'b0; dead_addr = '0; slv_dly = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_bus_req_", bus_req_, 1);
        chk("rst_cs_", cs_, 1);
        chk("rst_as_", as_, 1);
        chk("rst_rw", rw, 1);
        chk("rst_addr", addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1; count = 11'd0; start_addr = 30'h5;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_err", err, 0);
        chk("zero_bus_req_", bus_req_, 1);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        chk("zero_done_pulse", done, 0);
        chk("zero_bus_req_after", bus_req_, 1);
        for (int i = 0; i < 8; i++) run(tbl[i]);
        slv_dly = 5; dead_en = 1'b0;
        @(negedge clk);
        start = 1'b1; start_addr = 30'h80; count = 11'd4; bus_grnt_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_busy", busy, 1);
        chk("mid_bus_req_", bus_req_, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_bus_req_", bus_req_, 1);
        chk("async_cs_", cs_, 1);
        chk("async_as_", as_, 1);
        chk("async_busy", busy, 0);
        chk("async_addr", addr, 0);
        chk("async_out_valid", out_valid, 0);
        bus_grnt_ = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run(tbl[0]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
- Bus initiator that reads a run of consecutive words from the ROM, or any slave using the same cs_/as_/rdy_ handshake, and streams them to a local consumer.
- Used for boot-time copying and table loading.
- Arbitrates for the bus with req_/grnt_, issues one-cycle address strobes, waits for the slave's registered rdy_, then captures read data.
- Includes a per-access timeout so a dead slave cannot hang the system.

Parameters:
- ADDR_W, 30, word-address width driven on the bus.
- DATA_W, 32, bus data word width.
- CNT_W, 11, width of the transfer word count.
- TIMEOUT, 255, maximum cycles waited for rdy_ per access (1..2^16-1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- start_addr  in  ADDR_W  first word address
- count  in  CNT_W  number of words to read
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle pulse at end of burst, normal or error
- err  out  1  set with done on timeout; cleared by the next accepted start
- out_valid  out  1  one-cycle pulse per captured word
- out_data  out  DATA_W  captured word; held until next capture
- bus_req_  out  1  bus request, active-low
- bus_grnt_  in  1  bus grant, active-low
- cs_  out  1  slave chip select, active-low
- as_  out  1  address strobe, active-low
- rw  out  1  held at 1 (READ)
- addr  out  ADDR_W  bus word address
- rd_data  in  DATA_W  slave read data; valid when rdy_ is low
- rdy_  in  1  slave ready, active-low, registered by the slave

Behaviour:
- Reset (asynchronous, immediate, including mid-burst): state=IDLE; bus_req_=1, cs_=1, as_=1, rw=1; addr=0; busy=0, done=0, err=0, out_valid=0; out_data=0; internal counters=0.
- IDLE:
  - start=1 with count!=0: latch start_addr/count, clear err, go REQ.
  - start=1 with count==0: done=1 next cycle, err=0, no bus activity, stay IDLE.
  - start outside IDLE is ignored.
- REQ: bus_req_=0. On bus_grnt_=0, go ACCESS. Waiting for grant has no timeout.
- ACCESS, exactly one cycle: cs_=0, as_=0, addr=current address, bus_req_=0. Timeout counter cleared. Go WAIT.
- WAIT:
  - cs_=1, as_=1, addr held, bus_req_=0.
  - Each cycle with rdy_=1: timeout counter +1.
  - rdy_=0: out_data<=rd_data and out_valid=1 in the following cycle. Address +1, wrapping modulo 2^ADDR_W. Remaining count -1. If the new count is 0, go DONE; otherwise go ACCESS directly without re-arbitrating, because bus_req_ stays asserted.
  - Counter reaching TIMEOUT with rdy_ still 1: err<=1, go DONE, no out_valid. A rdy_ arriving on the same cycle as the limit wins, and the word is captured.
- DONE, one cycle: bus_req_=1, done=1, busy stays high this cycle. Go IDLE.
- Throughput with a rdy_-registered slave: ACCESS, WAIT(rdy_ low) repeating, so 2 cycles per word after grant.
- No consumer backpressure: the consumer must accept every out_valid pulse.
- Loss of grant mid-burst is not supported; the arbiter must hold grant while bus_req_ is low.

Test Plan:
- Normal burst: start_addr=0x10, count=4, grant immediate, model ROM with rdy_ registered on cs_&as_. Expect 4 out_valid pulses with data from 0x10..0x13, addr sequence 0x10..0x13, done once, err=0, bus_req_ released in DONE.
- Grant delay: hold bus_grnt_=1 for 7 cycles after start. Expect no as_ until grant, then identical data stream; total latency to first out_valid = 7 + 3 cycles.
- Zero count and ignored start: count=0 gives a done pulse with no bus_req_. A start pulse while busy leaves addr and count unaffected.
- Timeout: TIMEOUT=8, slave never asserts rdy_ on the second word. Expect exactly 1 out_valid, then done with err=1 at the 8th wait cycle. The next start clears err.
- Wrap: start_addr=2^30-2, count=3. Expect addr 0x3FFFFFFE, 0x3FFFFFFF, 0x00000000.
- Reset mid-burst: assert reset during WAIT. Expect bus_req_/cs_/as_ high and busy low immediately (asynchronous); a new burst after release operates normally.
